// File: rtl/seq_bit_tx.sv
// seq_bit_tx: serial bit-stream transmitter.
// Takes a parallel word over a valid/ready handshake and sends one framed bit
// per clock: a fixed preamble, then the word MSB-first, then an idle gap.
// Moore FSM; every output except the in_ready decode is a register.
module seq_bit_tx #(
    parameter int                 DATA_W     = 8,
    parameter int                 PRE_LEN    = 4,
    parameter logic [PRE_LEN-1:0] PREAMBLE   = 4'b1101,
    parameter int                 GAP_LEN    = 2,
    parameter logic               IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              out_valid,
    output logic              done,
    output logic [3:0]        state_out
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_PRE  = 4'd1,
        ST_DATA = 4'd2,
        ST_GAP  = 4'd3
    } state_t;

    // Terminal counts for each phase. The counter is wide enough for DATA_W=32.
    // GAP_LAST is only meaningful when GAP_LEN>0; the GAP state is unreachable otherwise.
    localparam logic [4:0] PRE_LAST  = 5'(PRE_LEN - 1);
    localparam logic [4:0] DATA_LAST = 5'(DATA_W - 1);
    localparam logic [4:0] GAP_LAST  = (GAP_LEN > 0) ? 5'(GAP_LEN - 1) : 5'd0;

    state_t              state_r;
    logic [4:0]          cnt_r;
    logic [DATA_W-1:0]   shreg_r;
    logic [PRE_LEN-1:0]  pre_sh_r;
    logic                out_r;
    logic                out_valid_r;
    logic                done_r;

    // Ready is a pure decode of the state register, so there is no path from in_valid.
    assign in_ready  = (state_r == ST_IDLE);
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign done      = done_r;
    assign state_out = state_r;

    // Frame sequencer: the outputs for the next cycle are computed with the next
    // state, so the bit on out always belongs to the state shown on state_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 5'd0;
            shreg_r     <= '0;
            pre_sh_r    <= '0;
            out_r       <= IDLE_LEVEL;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        // First preamble bit goes out in the cycle right after accept;
                        // the rest of the pattern is queued in pre_sh_r.
                        state_r     <= ST_PRE;
                        cnt_r       <= 5'd0;
                        shreg_r     <= in_data;
                        pre_sh_r    <= PREAMBLE << 1'b1;
                        out_r       <= PREAMBLE[PRE_LEN-1];
                        out_valid_r <= 1'b1;
                    end else begin
                        out_r       <= IDLE_LEVEL;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_PRE: begin
                    out_valid_r <= 1'b1;
                    if (cnt_r == PRE_LAST) begin
                        state_r <= ST_DATA;
                        cnt_r   <= 5'd0;
                        out_r   <= shreg_r[DATA_W-1];
                        shreg_r <= shreg_r << 1'b1;
                    end else begin
                        cnt_r    <= cnt_r + 5'd1;
                        out_r    <= pre_sh_r[PRE_LEN-1];
                        pre_sh_r <= pre_sh_r << 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == DATA_LAST) begin
                        cnt_r       <= 5'd0;
                        out_r       <= IDLE_LEVEL;
                        out_valid_r <= 1'b0;
                        if (GAP_LEN > 0) begin
                            state_r <= ST_GAP;
                        end else begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        cnt_r       <= cnt_r + 5'd1;
                        out_r       <= shreg_r[DATA_W-1];
                        out_valid_r <= 1'b1;
                        shreg_r     <= shreg_r << 1'b1;
                    end
                end
                ST_GAP: begin
                    out_r       <= IDLE_LEVEL;
                    out_valid_r <= 1'b0;
                    if (cnt_r == GAP_LAST) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 5'd0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= 5'd0;
                    out_r       <= IDLE_LEVEL;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bit_tx.sv
// Testbench for seq_bit_tx. Stimulus tasks drive the inputs just after a rising
// edge; a reference model pushes expected bits/done cycles into queues at accept
// time, and a monitor on the falling edge pops and compares them.
module tb_seq_bit_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data, in_data_g;
    logic       in_valid, in_valid_g;
    logic       in_ready, out, out_valid, done;
    logic [3:0] state_out;
    logic       in_ready_g, out_g, out_valid_g, done_g;
    logic [3:0] state_out_g;

    always #5 clk = ~clk;

    seq_bit_tx dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .done(done),
        .state_out(state_out)
    );

    seq_bit_tx #(.GAP_LEN(0)) dut_g0 (
        .clk(clk), .reset(reset), .in_data(in_data_g), .in_valid(in_valid_g),
        .in_ready(in_ready_g), .out(out_g), .out_valid(out_valid_g), .done(done_g),
        .state_out(state_out_g)
    );

    typedef struct {
        logic b;
        int   c;
    } exp_t;

    exp_t       exp_q[$];
    int         done_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         idle_at = 0;
    int         acc_c = -100;
    bit         loop_mode = 1'b0;
    int         det_cnt = 0;
    logic [3:0] det_sh = 4'b0000;
    logic [3:0] pre_pat = 4'b1101;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: cyc=%0d got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor first, then reference model, in one process so their order is fixed.
    always @(negedge clk) begin
        int   k;
        int   es;
        exp_t e;
        if (cyc >= 1) begin
            if (cyc >= idle_at) es = 0;
            else begin
                k  = cyc - acc_c;
                es = (k <= 4) ? 1 : ((k <= 12) ? 2 : 3);
            end
            chk("state_out", {28'd0, state_out}, es);
            chk("in_ready", {31'd0, in_ready}, (es == 0) ? 32'd1 : 32'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) chk("unexpected_bit", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("bit_cycle", cyc, e.c);
                    chk("bit_value", {31'd0, out}, {31'd0, e.b});
                end
            end else begin
                chk("idle_level", {31'd0, out}, 32'd0);
                if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                    chk("missing_bit", {31'd0, out_valid}, 32'd1);
                    void'(exp_q.pop_front());
                end
            end
            if (done) begin
                if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else chk("done_cycle", cyc, done_q.pop_front());
            end else if (done_q.size() > 0 && done_q[0] == cyc) begin
                chk("missing_done", {31'd0, done}, 32'd1);
                void'(done_q.pop_front());
            end
            det_sh = {det_sh[2:0], out};
            if (loop_mode && det_sh == 4'b1101) begin
                det_cnt++;
                chk("det_at_last_pre", {28'd0, state_out}, 32'd1);
            end
        end
        // Reference model: decide what the next edge does.
        if (reset) begin
            exp_q.delete();
            done_q.delete();
            idle_at = cyc + 1;
        end else if (cyc >= idle_at && in_valid) begin
            acc_c   = cyc;
            idle_at = cyc + 15;
            for (int i = 0; i < 4; i++) exp_q.push_back('{b: pre_pat[3-i], c: cyc + 1 + i});
            for (int i = 0; i < 8; i++) exp_q.push_back('{b: in_data[7-i], c: cyc + 5 + i});
            done_q.push_back(cyc + 15);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (cyc < idle_at && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] w);
        wait_idle();
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h96;
    endtask

    initial begin
        logic [3:0] st_exp[14];
        logic [13:0] out_exp;
        logic [3:0] g_sh;
        int gdet;

        // Reset held two cycles with in_valid high: no accept may happen.
        reset      = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h5A;
        in_valid_g = 1'b0;
        in_data_g  = 8'h00;
        repeat (2) tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();

        // Single A5 frame.
        send(8'hA5);
        wait_idle();
        repeat (3) tick();

        // Back-to-back with in_valid held: FF then 00, second accept in the done cycle.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick();
        in_data = 8'h00;
        repeat (15) tick();
        in_valid = 1'b0;
        wait_idle();
        repeat (2) tick();

        // Busy ignore: 3C pulses during PRE and DATA of an A5 frame.
        send(8'hA5);
        tick();
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        wait_idle();
        repeat (2) tick();

        // Reset after three payload bits, then a normal frame.
        send(8'hA5);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        send(8'h3C);
        wait_idle();
        repeat (2) tick();

        // Loopback into a 1101 detector with an all-zero payload.
        repeat (4) tick();
        det_cnt   = 0;
        loop_mode = 1'b1;
        send(8'h00);
        wait_idle();
        tick();
        loop_mode = 1'b0;
        chk("loop_det_count", det_cnt, 32'd1);

        // GAP_LEN=0 instance: hand-written state and bit sequence after accept.
        st_exp  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2,
                    4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0};
        out_exp = 14'b11010000000000;
        g_sh    = 4'b0000;
        gdet    = 0;
        in_valid_g = 1'b1;
        in_data_g  = 8'h00;
        tick();
        in_valid_g = 1'b0;
        in_data_g  = 8'hFF;
        for (int i = 0; i < 14; i++) begin
            chk("g0_state", {28'd0, state_out_g}, {28'd0, st_exp[i]});
            chk("g0_out", {31'd0, out_g}, {31'd0, out_exp[13-i]});
            chk("g0_out_valid", {31'd0, out_valid_g}, (i < 12) ? 32'd1 : 32'd0);
            chk("g0_done", {31'd0, done_g}, (i == 12) ? 32'd1 : 32'd0);
            g_sh = {g_sh[2:0], out_g};
            if (g_sh == 4'b1101) begin
                gdet++;
                chk("g0_det_position", i, 32'd3);
            end
            tick();
        end
        chk("g0_det_count", gdet, 32'd1);

        chk("bits_left", exp_q.size(), 32'd0);
        chk("dones_left", done_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case a task loop never returns.
    initial begin
        #200000;
        $display("FAIL global_timeout: cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
